// File: rtl/pdp8_sram_ctl.sv
// pdp8_sram_ctl
// Bridges the PDP-8 12-bit word / 15-bit address memory port onto the board's
// asynchronous 16-bit SRAM (ram1). Each request runs a fixed-length read or
// write sequence on the SRAM pins. Completion is reported with a single-cycle
// done pulse. All SRAM strobes and the status outputs come straight from
// flops, so the pins are glitch-free.

module pdp8_sram_ctl #(
  // Number of clk cycles the write strobe is held low per access (1..15).
  parameter int unsigned WAIT_CYCLES = 2,
  // Constant bank select driven on ram_a[17:15].
  parameter logic [2:0]  ADDR_HI     = 3'b000
) (
  input  logic        clk,
  input  logic        reset,      // synchronous, active low
  input  logic [14:0] addr,
  input  logic [11:0] data_in,
  input  logic        rd,
  input  logic        wr,
  output logic [11:0] data_out,
  output logic        done,
  output logic        busy,
  output logic [17:0] ram_a,
  output logic        ram_oe_n,
  output logic        ram_we_n,
  inout  wire  [15:0] ram1_io,
  output logic        ram1_ce_n,
  output logic        ram1_ub_n,
  output logic        ram1_lb_n
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD_ACT   = 3'd1;
  localparam logic [2:0] S_WR_SETUP = 3'd2;
  localparam logic [2:0] S_WR_PULSE = 3'd3;
  localparam logic [2:0] S_WR_HOLD  = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  // The read phase spends one cycle letting the address and OE_n settle
  // through the SRAM. It then waits WAIT_CYCLES further cycles before the
  // data is sampled, so the counter runs 0..WAIT_CYCLES.
  localparam logic [3:0] RD_LAST = 4'(WAIT_CYCLES);
  // The write pulse is exactly WAIT_CYCLES cycles wide, so the counter runs
  // 0..WAIT_CYCLES-1.
  localparam logic [3:0] WR_LAST = 4'(WAIT_CYCLES - 1);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [2:0]  r_state;
  logic [3:0]  r_cnt;
  logic [14:0] r_addr;
  logic [11:0] r_wdata;
  logic [11:0] r_data_out;
  logic        r_done;
  logic        r_busy;
  logic        r_oe_n;
  logic        r_we_n;
  logic        r_ce_n;
  logic        r_be_n;
  logic        r_bus_en;

  // --------------------------------------------------------------------------
  // Combinational next-state signals
  // --------------------------------------------------------------------------
  logic [2:0]  w_next_state;
  logic [3:0]  w_cnt_next;
  logic        w_accept;
  logic        w_rd_capture;
  logic        w_next_rd;
  logic        w_next_wr;
  logic        w_unused_io_hi;

  // The SRAM's upper nibble is wired but carries no PDP-8 data.
  assign w_unused_io_hi = ^ram1_io[15:12];

  // A request is only looked at while idle. Requests that arrive while busy
  // are dropped.
  assign w_accept     = (r_state == S_IDLE) && (wr || rd);

  // Read data is sampled on the edge that ends the last read cycle.
  assign w_rd_capture = (r_state == S_RD_ACT) && (r_cnt == RD_LAST);

  // Next-state and counter logic for the access sequencer.
  always_comb begin
    // NOTE: every output of this block gets a default first. Any path that
    // leaves one unassigned would infer a latch.
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        w_cnt_next = 4'd0;
        // Write wins when both strobes are high. The read is simply dropped.
        if (wr) begin
          w_next_state = S_WR_SETUP;
        end else if (rd) begin
          w_next_state = S_RD_ACT;
        end
      end
      S_RD_ACT: begin
        if (r_cnt == RD_LAST) begin
          w_next_state = S_DONE;
          w_cnt_next   = 4'd0;
        end else begin
          w_cnt_next   = r_cnt + 4'd1;
        end
      end
      S_WR_SETUP: begin
        w_next_state = S_WR_PULSE;
        w_cnt_next   = 4'd0;
      end
      S_WR_PULSE: begin
        if (r_cnt == WR_LAST) begin
          w_next_state = S_WR_HOLD;
          w_cnt_next   = 4'd0;
        end else begin
          w_cnt_next   = r_cnt + 4'd1;
        end
      end
      S_WR_HOLD: begin
        w_next_state = S_DONE;
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
        w_cnt_next   = 4'd0;
      end
    endcase
  end

  // Grouping of the next state into read/write phases, used to drive the pins.
  assign w_next_rd = (w_next_state == S_RD_ACT);
  assign w_next_wr = (w_next_state == S_WR_SETUP) ||
                     (w_next_state == S_WR_PULSE) ||
                     (w_next_state == S_WR_HOLD);

  // State and counter registers.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
    end
  end

  // Address and write-data latch. These load only when a request is
  // accepted, so ram_a and the driven bus value stay stable for the whole
  // access.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_addr  <= 15'd0;
      r_wdata <= 12'd0;
    end else if (w_accept) begin
      r_addr <= addr;
      if (wr) begin
        r_wdata <= data_in;
      end
    end
  end

  // Read data register. It holds the last completed read until the next one.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_data_out <= 12'd0;
    end else if (w_rd_capture) begin
      r_data_out <= ram1_io[11:0];
    end
  end

  // Registered pin strobes and status, decoded from the next state so that
  // each flop is high or low for exactly the cycles its state lasts. OE_n
  // and WE_n come from disjoint states, so they can never be low together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_oe_n   <= 1'b1;
      r_we_n   <= 1'b1;
      r_ce_n   <= 1'b1;
      r_be_n   <= 1'b1;
      r_bus_en <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_oe_n   <= !w_next_rd;
      r_we_n   <= !(w_next_state == S_WR_PULSE);
      r_ce_n   <= !(w_next_rd || w_next_wr);
      r_be_n   <= !(w_next_rd || w_next_wr);
      r_bus_en <= w_next_wr;
      r_done   <= (w_next_state == S_DONE);
      r_busy   <= (w_next_state != S_IDLE);
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign data_out  = r_data_out;
  assign done      = r_done;
  assign busy      = r_busy;
  assign ram_a     = {ADDR_HI, r_addr};
  assign ram_oe_n  = r_oe_n;
  assign ram_we_n  = r_we_n;
  assign ram1_ce_n = r_ce_n;
  assign ram1_ub_n = r_be_n;
  assign ram1_lb_n = r_be_n;

  // The bus is driven only during the write states, which never overlap
  // with OE_n low.
  assign ram1_io   = r_bus_en ? {4'b0000, r_wdata} : 'z;

endmodule
